// File: rtl/csa_slice_seq.sv
// csa_slice_seq: slice-serial add/subtract engine built around one 4-bit
// carry-select adder slice. Operands are captured on an in_valid/in_ready
// handshake, processed one nibble per cycle (LSB first) with the carry held
// in a register between cycles, and presented on an out_valid/out_ready
// handshake.
//
// Parameters:
//   WIDTH     operand/result width, multiple of 4 and >= 8
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake
//   a, b, cin, sub      operands; sub=1 computes a-b (cin ignored)
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, MSB carry-out (1 = no borrow on sub),
//                       two's-complement overflow
//   busy                engine not idle
module csa_slice_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_last;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [4:0]        w_s0;
    logic [4:0]        w_s1;
    logic [3:0]        w_slice_sum;
    logic              w_slice_co;

    assign w_last = (r_idx == IDXW'(NSLICE - 1));

    // Carry-select slice: both carry-in outcomes are formed, the registered
    // carry picks one.
    always_comb begin
        w_a_nib     = 4'(r_a >> (4 * r_idx));
        w_b_nib     = 4'(r_b >> (4 * r_idx));
        w_s0        = 5'(w_a_nib) + 5'(w_b_nib);
        w_s1        = 5'(w_a_nib) + 5'(w_b_nib) + 5'd1;
        w_slice_sum = r_carry ? w_s1[3:0] : w_s0[3:0];
        w_slice_co  = r_carry ? w_s1[4]   : w_s0[4];
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake/status flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Operand capture and per-slice datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                // Subtract as a + ~b + 1
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ? 1'b1 : cin;
                r_idx   <= '0;
                r_sum   <= '0;
            end else if (r_state == S_RUN) begin
                // sum was cleared on accept, so OR-in places each nibble
                r_sum   <= r_sum | (WIDTH'(w_slice_sum) << (4 * r_idx));
                r_carry <= w_slice_co;
                r_idx   <= r_idx + IDXW'(1);
                if (w_last) begin
                    r_cout <= w_slice_co;
                    r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_slice_sum[3] != r_a[MSB]);
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_slice_seq.sv
// Directed self-checking bench for csa_slice_seq (WIDTH=16 and WIDTH=8).
module tb_csa_slice_seq;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        sub8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;
    logic        busy8;

    int n_err;
    int n_chk;

    csa_slice_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    csa_slice_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full 16-bit operation: accept, scramble inputs, time the latency,
    // check the result, then consume it.
    task automatic op16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic isub,
                        input logic [15:0] es, input logic ec, input logic eo);
        int cnt;
        @(negedge clk);
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ia; b = 16'h5A5A; cin = ~icin; sub = ~isub;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_lat"}, 32'(cnt), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drain_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_ir"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cnt;
        logic [15:0] held_sum;
        logic        held_cout;
        logic        held_ovf;
        logic        stale;

        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;

        // Reset state
        #2;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Basic add, carry ripple, overflow, subtract
        op16("add_basic", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        op16("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        op16("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op16("sub_cin1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16("sub_cin0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Backpressure: result held, new request parked until drained
        @(negedge clk);
        a = 16'h1234; b = 16'h0FCD; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp_lat", 32'(cnt), 32'd4);
        held_sum = sum; held_cout = cout; held_ovf = ovf;
        chk("bp_sum_first", 32'(held_sum), 32'h2201);
        a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp_sum_stable", 32'(sum), 32'(held_sum));
            chk("bp_flags_stable", 32'({cout, ovf}), 32'({held_cout, held_ovf}));
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_ov", 32'(out_valid), 32'd0);
        chk("bp_release_ir", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_pending_busy", 32'(busy), 32'd1);
        chk("bp_pending_ir", 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp_pending_lat", 32'(cnt), 32'd4);
        chk("bp_pending_sum", 32'(sum), 32'h0003);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset two cycles into a run
        @(negedge clk);
        a = 16'h1234; b = 16'h0FCD; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        chk("mid_partial_sum", 32'(sum), 32'h0001);
        rst = 1'b1;
        #1;
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_post_ir", 32'(in_ready), 32'd1);
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) stale = 1'b1;
        end
        chk("mid_no_stale", 32'(stale), 32'd0);
        op16("post_rst", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);

        // WIDTH=8 instance
        @(negedge clk);
        a8 = 8'h34; b8 = 8'hCD; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        cnt = 0;
        while (!out_valid8 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("w8_lat", 32'(cnt), 32'd2);
        chk("w8_sum", 32'(sum8), 32'h01);
        chk("w8_cout", 32'(cout8), 32'd1);
        chk("w8_ovf", 32'(ovf8), 32'd0);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("w8_drain_ir", 32'(in_ready8), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/csa_slice_seq.md
Name: csa_slice_seq

Overview:
- Slice-serial add/subtract engine built around one shared 4-bit carry-select adder slice.
- Accepts WIDTH-bit operands over a valid/ready handshake, then feeds the slice one nibble per cycle, LSB first, with a registered carry between cycles.
- Presents the result, carry-out and signed overflow on a second valid/ready handshake.
- Gives wide adds a small area footprint where latency is not critical.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and >= 8.
- NSLICE, WIDTH/4, derived local value, not overridable; number of slice cycles per operation.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  engine can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high. While rst=1: state=IDLE, slice counter=0, carry reg=0, operand regs=0; outputs sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
- State IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid && in_ready.
  - On accept: a_r<=a; b_r<=sub ? ~b : b; carry<=sub ? 1 : cin; idx<=0; sum<=0; go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, the slice computes a_r[4*idx+:4] + b_r[4*idx+:4] + carry.
  - The slice sum is written to sum[4*idx+:4] and the slice carry to carry; idx increments.
  - When idx==NSLICE-1: cout<=slice carry; ovf<=(a_r[MSB]==b_r[MSB]) && (new sum[MSB]!=a_r[MSB]); go to DONE.
- State DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_valid && out_ready: go to IDLE and clear out_valid.
  - in_ready stays 0 in DONE; accept and output handshakes never overlap.
- Latency:
  - out_valid rises exactly NSLICE cycles after the accepting edge (4 cycles for WIDTH=16).
  - Minimum spacing between accepts is NSLICE+2 cycles.
- Input handling:
  - in_valid is ignored outside IDLE.
  - a, b, cin and sub are sampled only at the accepting edge; later changes have no effect on the operation in flight.
- Backpressure: out_ready low holds DONE indefinitely; no result is ever dropped or overwritten.
- Observability of sum: sum is observable during RUN (partially filled) but is defined only while out_valid=1.
- Carry handling: carry ripples between slices only through the carry register; there is no combinational path from the operand inputs to the outputs.
- Reset mid-operation: asserting rst in RUN or DONE aborts immediately; all outputs take their reset values asynchronously; no partial result is later presented.
- Width rules:
  - sum wraps modulo 2^WIDTH.
  - cout is the carry-out of bit WIDTH-1.
  - ovf uses the effective (inverted for sub) B operand.

Test Plan:
1. Basic add, WIDTH=16: a=0x1234, b=0x0FCD, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=0x2201, cout=0, ovf=0.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
3. Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Sub a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Subtract with borrow, cin ignored: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0. Same operands with cin=0 -> identical result.
5. Backpressure:
   - Hold out_ready=0 for 6 cycles after out_valid rises -> sum, cout and ovf stay stable; in_ready=0; a new in_valid is not accepted.
   - Raise out_ready -> next cycle IDLE, in_ready=1, and the pending request is accepted.
6. Reset mid-run and parameter check:
   - Assert rst two cycles after accept -> sum=0, out_valid=0, busy=0 immediately; after release, in_ready=1 and no stale result appears.
   - Repeat test 1 with WIDTH=8 on a=0x34, b=0xCD -> sum=0x01, cout=1, out_valid 2 cycles after accept.
